// File: rtl/cpu_control_fsm.sv
// Multi-cycle control sequencer for the 8-bit datapath: fetches 16-bit instructions,
// decodes them into register-file/ALU controls and owns the program counter.
module cpu_control_fsm (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [7:0]  imem_addr,
   input  logic        imem_ack,
   input  logic [15:0] imem_data,
   input  logic        take_branch,
   input  logic        ovf,
   output logic        RegWrite,
   output logic [1:0]  ReadAddr1,
   output logic [1:0]  ReadAddr2,
   output logic [1:0]  WriteAddr,
   output logic [7:0]  Instr_i,
   output logic        ALUSrc1,
   output logic        ALUSrc2,
   output logic [2:0]  ALUOp,
   output logic [7:0]  pc,
   output logic        halted,
   output logic        ovf_sticky
);

   typedef enum logic [1:0] {S_FETCH, S_EXEC, S_WB, S_HALTED} state_t;

   state_t      state;
   logic [15:0] ir;
   logic [1:0]  cls;
   logic [2:0]  op;
   logic [1:0]  ra;
   logic [1:0]  rb;
   logic [7:0]  imm;
   logic        is_halt;

   assign cls       = ir[15:14];
   assign op        = ir[13:11];
   assign ra        = ir[10:9];
   assign rb        = ir[1:0];
   assign imm       = ir[7:0];
   assign is_halt   = (ir == 16'hFFFF);
   assign imem_addr = pc;

   // Controls come straight from IR, so they only move on the capture edge.
   always_comb begin
      ReadAddr1 = ra;
      ReadAddr2 = 2'd0;
      WriteAddr = ra;
      ALUSrc1   = 1'b0;
      ALUSrc2   = 1'b0;
      ALUOp     = op;
      Instr_i   = imm;
      case (cls)
         2'b00: ReadAddr2 = rb;
         2'b01: ALUSrc2 = 1'b1;
         2'b10: begin
            ReadAddr1 = 2'd0;
            ALUSrc1   = 1'b1;
            ALUSrc2   = 1'b1;
            ALUOp     = 3'b000;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_FETCH;
         pc         <= 8'd0;
         ir         <= 16'd0;
         imem_req   <= 1'b0;
         RegWrite   <= 1'b0;
         halted     <= 1'b0;
         ovf_sticky <= 1'b0;
      end else begin
         case (state)
            S_FETCH: begin
               imem_req <= 1'b1;
               // An ack is only honoured once the request is actually on the port.
               if (imem_req && imem_ack) begin
                  ir       <= imem_data;
                  imem_req <= 1'b0;
                  state    <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (is_halt) begin
                  halted <= 1'b1;
                  state  <= S_HALTED;
               end else if (cls == 2'b11) begin
                  // Two's-complement offset wraps modulo 256 like the PC itself.
                  pc       <= take_branch ? (pc + 8'd1 + imm) : (pc + 8'd1);
                  imem_req <= 1'b1;
                  state    <= S_FETCH;
               end else begin
                  RegWrite <= 1'b1;
                  state    <= S_WB;
               end
            end
            S_WB: begin
               RegWrite <= 1'b0;
               pc       <= pc + 8'd1;
               if (ovf) ovf_sticky <= 1'b1;
               imem_req <= 1'b1;
               state    <= S_FETCH;
            end
            default: begin
               imem_req <= 1'b0;
               RegWrite <= 1'b0;
               halted   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Scoreboard bench for cpu_control_fsm: a stimulus process issues instructions and queues
// expected fetches/write-backs from an instruction-level model; a monitor pops and compares.
module tb_cpu_control_fsm;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req;
   logic [7:0]  imem_addr;
   logic        imem_ack = 1'b0;
   logic [15:0] imem_data = 16'd0;
   logic        take_branch = 1'b0;
   logic        ovf = 1'b0;
   logic        RegWrite;
   logic [1:0]  ReadAddr1, ReadAddr2, WriteAddr;
   logic [7:0]  Instr_i;
   logic        ALUSrc1, ALUSrc2;
   logic [2:0]  ALUOp;
   logic [7:0]  pc;
   logic        halted, ovf_sticky;

   cpu_control_fsm dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_data(imem_data), .take_branch(take_branch), .ovf(ovf),
      .RegWrite(RegWrite), .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2),
      .WriteAddr(WriteAddr), .Instr_i(Instr_i), .ALUSrc1(ALUSrc1), .ALUSrc2(ALUSrc2),
      .ALUOp(ALUOp), .pc(pc), .halted(halted), .ovf_sticky(ovf_sticky)
   );

   always #5 clk = ~clk;

   typedef struct {logic [7:0] addr; logic sticky; int gap;} fetch_t;
   typedef struct {logic [1:0] cls; logic [1:0] ra; logic [1:0] rb; logic [2:0] op; logic [7:0] imm;} wb_t;

   fetch_t     fetch_q[$];
   wb_t        wb_q[$];
   int         checks = 0;
   int         failures = 0;
   logic [7:0] m_pc;
   logic       m_sticky;
   int         m_lat;
   int         gap;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_req"}, 16'(imem_req), 16'd0);
      chk({tag, "_pc"}, 16'(pc), 16'd0);
      chk({tag, "_addr"}, 16'(imem_addr), 16'd0);
      chk({tag, "_we"}, 16'(RegWrite), 16'd0);
      chk({tag, "_halted"}, 16'(halted), 16'd0);
      chk({tag, "_sticky"}, 16'(ovf_sticky), 16'd0);
      chk({tag, "_ctrl"}, {ReadAddr1, ReadAddr2, WriteAddr, ALUSrc1, ALUSrc2, ALUOp, 5'd0}, 16'd0);
      chk({tag, "_imm"}, 16'(Instr_i), 16'd0);
   endtask

   // Monitor: compares every write-back and every fetch against the queued expectations.
   always @(negedge clk) begin : mon
      wb_t    e;
      fetch_t f;
      if (!rst) begin
         gap = 0;
      end else begin
         gap++;
         if (RegWrite) begin
            if (wb_q.size() == 0) begin
               chk("unexpected_write", 16'(RegWrite), 16'd0);
            end else begin
               e = wb_q.pop_front();
               chk("wb_waddr", 16'(WriteAddr), 16'(e.ra));
               chk("wb_aluop", 16'(ALUOp), 16'((e.cls == 2'd2) ? 3'd0 : e.op));
               chk("wb_imm", 16'(Instr_i), 16'(e.imm));
               chk("wb_src1", 16'(ALUSrc1), 16'(e.cls == 2'd2));
               chk("wb_src2", 16'(ALUSrc2), 16'(e.cls != 2'd0));
               if (e.cls != 2'd2) chk("wb_raddr1", 16'(ReadAddr1), 16'(e.ra));
               if (e.cls == 2'd0) chk("wb_raddr2", 16'(ReadAddr2), 16'(e.rb));
            end
         end
         if (imem_req) begin
            if (fetch_q.size() == 0) begin
               chk("unexpected_req", 16'(imem_req), 16'd0);
            end else begin
               f = fetch_q[0];
               chk("fetch_addr", 16'(imem_addr), 16'(f.addr));
               chk("fetch_pc", 16'(pc), 16'(f.addr));
               if (imem_ack) begin
                  void'(fetch_q.pop_front());
                  chk("sticky", 16'(ovf_sticky), 16'(f.sticky));
                  chk("halted_low", 16'(halted), 16'd0);
                  if (f.gap >= 0) chk("latency", 16'(gap), 16'(f.gap));
                  gap = 0;
               end
            end
         end
      end
   end

   function automatic logic [15:0] rand_instr(input logic [1:0] cls);
      logic [15:0] v;
      v = 16'($urandom);
      v[15:14] = cls;
      if (v == 16'hFFFF) v[8] = 1'b0;
      return v;
   endfunction

   // Serve one fetch after w wait cycles and advance the instruction-level model.
   task automatic issue(input logic [15:0] instr, input logic tb_v, input logic ovf_v, input int w);
      logic [7:0] imm;
      logic [1:0] cls;
      int n;
      fetch_q.push_back('{addr: m_pc, sticky: m_sticky, gap: (m_lat < 0) ? -1 : m_lat + w});
      n = 0;
      while (!imem_req && n < 20) begin
         imem_ack  = (m_lat >= 0) ? 1'($urandom) : 1'b0;
         imem_data = 16'($urandom);
         @(posedge clk); #2;
         n++;
      end
      imem_ack = 1'b0;
      chk("req_seen", 16'(imem_req), 16'd1);
      repeat (w) begin
         imem_data = 16'($urandom);
         @(posedge clk); #2;
      end
      imem_ack    = 1'b1;
      imem_data   = instr;
      take_branch = tb_v;
      ovf         = ovf_v;
      cls = instr[15:14];
      imm = instr[7:0];
      if (instr == 16'hFFFF) begin
         m_lat = -1;
      end else if (cls == 2'b11) begin
         if (tb_v) m_pc = 8'((int'(m_pc) + 1 + int'($signed(imm))) & 255);
         else      m_pc = 8'((int'(m_pc) + 1) & 255);
         m_lat = 2;
      end else begin
         wb_q.push_back('{cls: cls, ra: instr[10:9], rb: instr[1:0], op: instr[13:11], imm: imm});
         m_pc     = 8'((int'(m_pc) + 1) & 255);
         m_sticky = m_sticky | ovf_v;
         m_lat    = 3;
      end
      @(posedge clk); #2;
      imem_ack = 1'b0;
   endtask

   task automatic release_reset(input string tag);
      fetch_q.delete();
      wb_q.delete();
      m_pc = 8'd0; m_sticky = 1'b0; m_lat = -1;
      @(posedge clk); #2;
      rst = 1'b1;
      #1 chk({tag, "_req_before_edge"}, 16'(imem_req), 16'd0);
      @(posedge clk); #2;
      chk({tag, "_req_rises"}, 16'(imem_req), 16'd1);
      chk({tag, "_first_addr"}, 16'(imem_addr), 16'd0);
   endtask

   task automatic reset_mid_fetch();
      int n;
      fetch_q.push_back('{addr: m_pc, sticky: m_sticky, gap: -1});
      n = 0;
      while (!imem_req && n < 20) begin
         @(posedge clk); #2;
         n++;
      end
      chk("rmf_req_seen", 16'(imem_req), 16'd1);
      repeat (2) begin @(posedge clk); #2; end
      chk("rmf_req_held", 16'(imem_req), 16'd1);
      chk("rmf_addr_held", 16'(imem_addr), 16'(m_pc));
      #1 rst = 1'b0;
      #1 chk_reset("rmf");
      release_reset("rmf");
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: time %0t reached limit 500000", $time);
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [1:0] c;
      logic [7:0] wimm;
      m_pc = 8'd0; m_sticky = 1'b0; m_lat = -1; gap = 0;
      rst = 1'b1;
      #1 rst = 1'b0;
      #2 chk_reset("por");
      release_reset("por");

      // Overflow is raised only alongside branches here, so the sticky flag must stay low.
      for (int i = 0; i < 30; i++) begin
         c = 2'($urandom);
         issue(rand_instr(c), 1'($urandom), 1'(c == 2'b11), int'($urandom_range(0, 3)));
      end

      reset_mid_fetch();

      issue(16'h825A, 1'b0, 1'b0, 3);
      issue(16'h1403, 1'b0, 1'b1, 0);
      for (int i = 0; i < 3; i++) issue(rand_instr(2'b10), 1'b0, 1'b0, int'($urandom_range(0, 2)));
      issue(16'hE2FE, 1'b1, 1'b0, 0);
      @(posedge clk); #2;
      chk("branch_taken_pc", 16'(pc), 16'h0004);
      issue(16'h4A11, 1'b0, 1'b0, 1);
      issue(16'hE2FE, 1'b0, 1'b1, 0);
      @(posedge clk); #2;
      chk("branch_not_taken_pc", 16'(pc), 16'h0006);

      for (int i = 0; i < 120; i++)
         issue(rand_instr(2'($urandom)), 1'($urandom), 1'($urandom_range(0, 2) == 0),
               int'($urandom_range(0, 3)));

      // Branch to FF, then a write-back there must wrap the PC to 00.
      wimm = 8'(8'hFE - m_pc);
      issue({2'b11, 3'($urandom), 2'($urandom), 1'b0, wimm}, 1'b1, 1'b0, 0);
      issue(16'h0000, 1'b0, 1'b0, 0);
      issue(16'hFFFF, 1'b0, 1'b0, int'($urandom_range(0, 3)));
      @(posedge clk); #2;
      chk("halted_set", 16'(halted), 16'd1);
      for (int i = 0; i < 20; i++) begin
         imem_ack  = 1'($urandom);
         imem_data = 16'($urandom);
         @(posedge clk); #2;
         chk("halt_req", 16'(imem_req), 16'd0);
         chk("halt_we", 16'(RegWrite), 16'd0);
         chk("halt_stays", 16'(halted), 16'd1);
      end
      imem_ack = 1'b0;
      chk("wb_drained", 16'(wb_q.size()), 16'd0);
      chk("fetch_drained", 16'(fetch_q.size()), 16'd0);
      rst = 1'b0;
      #1 chk_reset("halt_rst");
      @(posedge clk); #2;
      rst = 1'b1;
      @(posedge clk); #2;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
